ili9341_spi_arbiter: RTL

Shares the single SPI link to the ILI9341 panel between two requesters: a command/parameter port (init sequencer, window setup) and a pixel-stream port (RGB565 frame writer). Serializes the granted transfer in SPI mode 0 with SCK derived from `i_clk_FPGA` by an internal half-period counter, and drives CS_n and D/C. Sits between the display control logic and the PYNQ pins.

---
 rtl/ili9341_spi_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ili9341_spi_arbiter.sv
// ---------------------------------------------------------------------------
// ili9341_spi_arbiter
//
// Shares one SPI link to an ILI9341 panel between a command/parameter
// requester and an RGB565 pixel-stream requester. The granted word is
// shifted out in SPI mode 0, MSB first. SCK is derived from i_clk_FPGA by a
// half-period counter. Every transfer is followed by a CS-high gap.
//
// Optional build macro:
//   ROUND_ROBIN_EN - on a tie, grant the port that was not granted most
//                    recently (the pointer starts at "pixel last"). Without
//                    it, command always beats pixel on a tie.
//
// Parameters:
//   FRECUENCY_IN  - input clock frequency in Hz
//   FRECUENCY_OUT - target SCK frequency in Hz
//
// Ports:
//   i_clk_FPGA  - single clock
//   i_rst       - synchronous active-high reset
//   i_cmd_req   - command byte pending
//   i_cmd_dc    - D/C level for the command byte (0 command, 1 parameter)
//   i_cmd_data  - command byte
//   o_cmd_ack   - one-cycle pulse, command byte accepted
//   i_pix_req   - pixel pending
//   i_pix_data  - RGB565 pixel, sent as 16 bits with D/C = 1
//   o_pix_ack   - one-cycle pulse, pixel accepted
//   o_spi_sck   - SPI clock, idles low
//   o_spi_mosi  - serial data
//   o_spi_cs_n  - chip select, active low
//   o_spi_dc    - data/command select
//   o_busy      - high whenever a transfer or its gap is in progress
// ---------------------------------------------------------------------------
module ili9341_spi_arbiter #(
  parameter int FRECUENCY_IN  = 125000000,
  parameter int FRECUENCY_OUT = 10000000
) (
  input  logic        i_clk_FPGA,
  input  logic        i_rst,
  input  logic        i_cmd_req,
  input  logic        i_cmd_dc,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_ack,
  input  logic        i_pix_req,
  input  logic [15:0] i_pix_data,
  output logic        o_pix_ack,
  output logic        o_spi_sck,
  output logic        o_spi_mosi,
  output logic        o_spi_cs_n,
  output logic        o_spi_dc,
  output logic        o_busy
);

  localparam int HALF = (FRECUENCY_IN / FRECUENCY_OUT) / 2;
  localparam int HW   = (HALF < 1) ? 1 : $clog2(HALF + 1);
  localparam logic [HW-1:0] HALF_M1 = HW'(HALF - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // A clock ratio below 2 cannot produce an SCK half period.
  if (HALF < 1) begin : g_half_check
    $error("ili9341_spi_arbiter: HALF must be at least 1");
  end

  logic [1:0]    state;
  logic [HW-1:0] half_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    num_bits;
  logic [15:0]   shift_reg;
  logic          grant_cmd;
  logic          grant_pix;
`ifdef ROUND_ROBIN_EN
  logic          last_pix;
`endif

  // Arbitration between the two requesters, only acted on in IDLE. The
  // round-robin build uses the last-grant pointer to break ties; a lone
  // requester always wins in either build.
  always_comb begin
`ifdef ROUND_ROBIN_EN
    grant_cmd = i_cmd_req & (~i_pix_req | last_pix);
`else
    grant_cmd = i_cmd_req;
`endif
    grant_pix = i_pix_req & ~grant_cmd;
  end

  // Main sequencer. IDLE latches the granted word (commands left-aligned so
  // the MSB always sits in bit 15) and presents the first bit. SHIFT toggles
  // SCK every HALF cycles and advances MOSI after each falling toggle until
  // N bits have gone out. GAP keeps CS_n high for HALF cycles so the panel
  // always sees a deselect between transfers; CS_n is raised by GAP itself,
  // so the final SCK falling edge and the CS_n rise land on separate cycles.
  always_ff @(posedge i_clk_FPGA) begin
    if (i_rst) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      num_bits   <= '0;
      shift_reg  <= '0;
      o_cmd_ack  <= 1'b0;
      o_pix_ack  <= 1'b0;
      o_spi_sck  <= 1'b0;
      o_spi_mosi <= 1'b0;
      o_spi_cs_n <= 1'b1;
      o_spi_dc   <= 1'b0;
      o_busy     <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_pix   <= 1'b1;
`endif
    end else begin
      o_cmd_ack <= 1'b0;
      o_pix_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cmd || grant_pix) begin
            shift_reg  <= grant_cmd ? {i_cmd_data, 8'h00} : i_pix_data;
            num_bits   <= grant_cmd ? 5'd8 : 5'd16;
            o_spi_dc   <= grant_cmd ? i_cmd_dc : 1'b1;
            o_spi_mosi <= grant_cmd ? i_cmd_data[7] : i_pix_data[15];
            o_cmd_ack  <= grant_cmd;
            o_pix_ack  <= grant_pix;
            o_spi_cs_n <= 1'b0;
            o_busy     <= 1'b1;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
`ifdef ROUND_ROBIN_EN
            last_pix   <= grant_pix;
`endif
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_M1) begin
            half_cnt  <= '0;
            o_spi_sck <= ~o_spi_sck;
            if (o_spi_sck) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt + 5'd1 == num_bits) begin
                state <= GAP;
              end else begin
                o_spi_mosi <= shift_reg[14];
                shift_reg  <= {shift_reg[14:0], 1'b0};
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        GAP: begin
          o_spi_cs_n <= 1'b1;
          o_spi_sck  <= 1'b0;
          if (half_cnt == HALF_M1) begin
            half_cnt <= '0;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
